// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - signal bundle between the sequencer/data bus side and irq_ctrl
//
// Ports (all carried as interface signals):
//   irq_src[7:0]  asynchronous rising-edge interrupt lines
//   fault_in[1:0] single-cycle fault strobes (bit0 illegal opcode, bit1 bus error)
//   state[3:0]    sequencer state, 4'b0000 is the trap/halt state
//   reti          return-from-interrupt strobe
//   we/addr/wdata register write port, rdata combinational read data
//   irq_r/fault_r requests to the sequencer
//   cause/vector  latched cause and handler address
interface irq_ctrl_if;
    logic [7:0]  irq_src;
    logic [1:0]  fault_in;
    logic [3:0]  state;
    logic        reti;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        irq_r;
    logic        fault_r;
    logic [3:0]  cause;
    logic [15:0] vector;

    modport master (
        output irq_src, fault_in, state, reti, we, addr, wdata,
        input  rdata, irq_r, fault_r, cause, vector
    );

    modport slave (
        input  irq_src, fault_in, state, reti, we, addr, wdata,
        output rdata, irq_r, fault_r, cause, vector
    );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - 8-line edge interrupt controller with fault capture and vectoring
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    irq_ctrl_if.slave: irq_src, fault_in, state, reti, we/addr/wdata,
//          rdata, irq_r, fault_r, cause, vector
// Registers: 0 MASK[7:0], 1 PEND[7:0] (W1C), 2 CTRL {PIE, INSV, IE}, 3 BASE[15:2]
module irq_ctrl (
    input  logic      clk,
    input  logic      reset,
    irq_ctrl_if.slave bus
);
    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_BASE = 2'd3;

    logic [7:0]  sync1_q, sync2_q, prev_q;
    logic [2:0]  fill_q;
    logic [7:0]  mask_q, pend_q;
    logic        ie_q, insv_q, pie_q;
    logic [15:0] base_q;
    logic [3:0]  cause_q;
    logic        fault_r_q, fault_src_q;
    logic        irq_r_q;
    logic        trap_q;

    logic [7:0]  mask_n, pend_n;
    logic        ie_n, insv_n, pie_n;
    logic [15:0] base_n;
    logic [3:0]  cause_n;
    logic        fault_r_n, fault_src_n;

    logic [7:0]  edge_det;
    logic [7:0]  pend_masked;
    logic        irq_found;
    logic [2:0]  irq_idx;
    logic        in_trap, ack_edge, fault_ack, irq_ack;
    logic        wr_mask, wr_pend, wr_ctrl, wr_base;
    logic        ie_eff;

    // fill_q marks when prev_q holds a genuine post-reset sample, so a line
    // already high when reset drops never looks like a fresh rising edge.
    assign edge_det    = sync2_q & ~prev_q & {8{fill_q[2]}};
    assign pend_masked = pend_q & mask_q;

    // Lowest-index pending-and-enabled line; descending scan so index 0 wins.
    always_comb begin
        irq_found = 1'b0;
        irq_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_masked[i]) begin
                irq_found = 1'b1;
                irq_idx   = i[2:0];
            end
        end
    end

    // One acknowledge opportunity per entry into the trap state.
    assign in_trap   = (bus.state == 4'b0000);
    assign ack_edge  = in_trap & ~trap_q;
    assign fault_ack = ack_edge & fault_r_q;
    assign irq_ack   = ack_edge & ~fault_r_q & irq_r_q;

    assign wr_mask = bus.we & (bus.addr == ADDR_MASK);
    assign wr_pend = bus.we & (bus.addr == ADDR_PEND);
    assign wr_ctrl = bus.we & (bus.addr == ADDR_CTRL);
    assign wr_base = bus.we & (bus.addr == ADDR_BASE);

    // IE as seen by an ack in the same cycle as reti: the restored value.
    assign ie_eff = bus.reti ? pie_q : ie_q;

    always_comb begin
        mask_n      = mask_q;
        pend_n      = pend_q;
        ie_n        = ie_q;
        insv_n      = insv_q;
        pie_n       = pie_q;
        base_n      = base_q;
        cause_n     = cause_q;
        fault_r_n   = fault_r_q;
        fault_src_n = fault_src_q;

        if (wr_mask) mask_n = bus.wdata[7:0];
        if (wr_base) base_n = {bus.wdata[15:2], 2'b00};

        // Clears first, then new edges OR in so a coincident set wins.
        if (wr_pend) pend_n = pend_n & ~bus.wdata[7:0];
        if (irq_ack && irq_found) pend_n[irq_idx] = 1'b0;
        pend_n = pend_n | edge_det;

        // IE priority: ack > reti > bus write.
        if (wr_ctrl) ie_n = bus.wdata[0];
        if (bus.reti) begin
            ie_n   = pie_q;
            insv_n = 1'b0;
        end

        if (!fault_r_q && (|bus.fault_in)) begin
            fault_r_n   = 1'b1;
            fault_src_n = ~bus.fault_in[0];
        end

        if (fault_ack) begin
            cause_n   = {3'b100, fault_src_q};
            fault_r_n = 1'b0;
        end else if (irq_ack) begin
            cause_n = {1'b0, irq_idx};
        end

        if (fault_ack || irq_ack) begin
            insv_n = 1'b1;
            pie_n  = ie_eff;
            ie_n   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            fill_q      <= '0;
            mask_q      <= '0;
            pend_q      <= '0;
            ie_q        <= 1'b0;
            insv_q      <= 1'b0;
            pie_q       <= 1'b0;
            base_q      <= '0;
            cause_q     <= '0;
            fault_r_q   <= 1'b0;
            fault_src_q <= 1'b0;
            irq_r_q     <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            sync1_q     <= bus.irq_src;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            fill_q      <= {fill_q[1:0], 1'b1};
            mask_q      <= mask_n;
            pend_q      <= pend_n;
            ie_q        <= ie_n;
            insv_q      <= insv_n;
            pie_q       <= pie_n;
            base_q      <= base_n;
            cause_q     <= cause_n;
            fault_r_q   <= fault_r_n;
            fault_src_q <= fault_src_n;
            // Built from next-state values so irq_r always matches the
            // registers it sits beside (drops the cycle after an ack).
            irq_r_q     <= ie_n & ~insv_n & ~fault_r_n & (|(pend_n & mask_n));
            trap_q      <= in_trap;
        end
    end

    always_comb begin
        bus.rdata = 16'h0000;
        case (bus.addr)
            ADDR_MASK: bus.rdata = {8'h00, mask_q};
            ADDR_PEND: bus.rdata = {8'h00, pend_q};
            ADDR_CTRL: bus.rdata = {13'h0000, pie_q, insv_q, ie_q};
            ADDR_BASE: bus.rdata = base_q;
            default:   bus.rdata = 16'h0000;
        endcase
    end

    assign bus.irq_r   = irq_r_q;
    assign bus.fault_r = fault_r_q;
    assign bus.cause   = cause_q;
    assign bus.vector  = base_q + {10'h000, cause_q, 2'b00};
endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    irq_ctrl_if bus ();

    irq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        step();
        bus.we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
        bus.addr = a;
        #1;
        check(tag, bus.rdata, exp);
    endtask

    task automatic ack();
        bus.state = 4'h0;
        step();
        bus.state = 4'h1;
    endtask

    task automatic reti_pulse();
        bus.reti = 1'b1;
        step();
        bus.reti = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.irq_src  = 8'h00;
        bus.fault_in = 2'b00;
        bus.state    = 4'h1;
        bus.reti     = 1'b0;
        bus.we       = 1'b0;
        bus.addr     = 2'd0;
        bus.wdata    = 16'h0000;
        steps(2);
        reset = 1'b0;
        step();

        // Reset state
        rd("rst_mask", 2'd0, 16'h0000);
        rd("rst_pend", 2'd1, 16'h0000);
        rd("rst_ctrl", 2'd2, 16'h0000);
        rd("rst_base", 2'd3, 16'h0000);
        check("rst_irq_r", {15'd0, bus.irq_r}, 16'd0);
        check("rst_fault_r", {15'd0, bus.fault_r}, 16'd0);
        check("rst_cause", {12'd0, bus.cause}, 16'd0);
        check("rst_vector", bus.vector, 16'h0000);

        // BASE low bits forced to zero
        wr(2'd3, 16'h1003);
        rd("base_low_bits", 2'd3, 16'h1000);

        // Single masked-in irq on line 2
        wr(2'd0, 16'h0005);
        wr(2'd2, 16'h0001);
        bus.irq_src = 8'h04;
        steps(3);
        bus.irq_src = 8'h00;
        rd("l2_pend", 2'd1, 16'h0004);
        check("l2_irq_r", {15'd0, bus.irq_r}, 16'd1);
        ack();
        check("l2_cause", {12'd0, bus.cause}, 16'd2);
        rd("l2_pend_clr", 2'd1, 16'h0000);
        rd("l2_ctrl", 2'd2, 16'h0006);
        check("l2_vector", bus.vector, 16'h1008);
        check("l2_irq_r_drop", {15'd0, bus.irq_r}, 16'd0);
        reti_pulse();
        rd("l2_reti_ctrl", 2'd2, 16'h0005);

        // Two pending, lowest first, re-raise after reti
        wr(2'd0, 16'h00FF);
        bus.irq_src = 8'h0A;
        steps(3);
        bus.irq_src = 8'h00;
        rd("two_pend", 2'd1, 16'h000A);
        check("two_irq_r", {15'd0, bus.irq_r}, 16'd1);
        ack();
        check("two_cause1", {12'd0, bus.cause}, 16'd1);
        rd("two_pend_after1", 2'd1, 16'h0008);
        check("two_irq_r_in_svc", {15'd0, bus.irq_r}, 16'd0);
        reti_pulse();
        rd("two_reti_ctrl", 2'd2, 16'h0005);
        check("two_irq_r_again", {15'd0, bus.irq_r}, 16'd1);
        ack();
        check("two_cause3", {12'd0, bus.cause}, 16'd3);
        check("two_vector", bus.vector, 16'h100C);
        rd("two_pend_empty", 2'd1, 16'h0000);
        reti_pulse();

        // Bus-error fault with IE=0 and a pending irq; later fault ignored
        wr(2'd2, 16'h0000);
        rd("flt_ctrl_pre", 2'd2, 16'h0004);
        bus.irq_src = 8'h10;
        steps(3);
        bus.irq_src = 8'h00;
        rd("flt_pend", 2'd1, 16'h0010);
        bus.fault_in = 2'b10;
        step();
        bus.fault_in = 2'b00;
        check("flt_fault_r", {15'd0, bus.fault_r}, 16'd1);
        bus.fault_in = 2'b01;
        step();
        bus.fault_in = 2'b00;
        ack();
        check("flt_cause", {12'd0, bus.cause}, 16'd9);
        check("flt_fault_r_clr", {15'd0, bus.fault_r}, 16'd0);
        check("flt_irq_r", {15'd0, bus.irq_r}, 16'd0);
        check("flt_vector", bus.vector, 16'h1024);
        rd("flt_ctrl", 2'd2, 16'h0002);
        reti_pulse();
        rd("flt_reti_ctrl", 2'd2, 16'h0000);
        wr(2'd1, 16'h0010);
        rd("flt_w1c", 2'd1, 16'h0000);

        // Edge coincident with W1C of the same bit: set wins
        bus.irq_src = 8'h01;
        steps(2);
        wr(2'd1, 16'h0001);
        rd("set_wins", 2'd1, 16'h0001);
        bus.irq_src = 8'h00;
        wr(2'd1, 16'h0001);
        rd("set_wins_clr", 2'd1, 16'h0000);

        // Masked pending line, then unmask
        wr(2'd0, 16'h0000);
        wr(2'd2, 16'h0001);
        bus.irq_src = 8'h80;
        steps(3);
        bus.irq_src = 8'h00;
        rd("mask_pend", 2'd1, 16'h0080);
        check("mask_irq_r_off", {15'd0, bus.irq_r}, 16'd0);
        wr(2'd0, 16'h0080);
        check("mask_irq_r_on", {15'd0, bus.irq_r}, 16'd1);

        // Ack coincident with CTRL.IE write: ack wins
        bus.we    = 1'b1;
        bus.addr  = 2'd2;
        bus.wdata = 16'h0001;
        ack();
        bus.we    = 1'b0;
        check("ack_cause7", {12'd0, bus.cause}, 16'd7);
        check("ack_vector7", bus.vector, 16'h101C);
        rd("ack_wins_ctrl", 2'd2, 16'h0006);

        // Reset mid-service with a line held high
        bus.irq_src = 8'h08;
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        step();
        rd("rst2_mask", 2'd0, 16'h0000);
        rd("rst2_ctrl", 2'd2, 16'h0000);
        rd("rst2_base", 2'd3, 16'h0000);
        check("rst2_cause", {12'd0, bus.cause}, 16'd0);
        check("rst2_vector", bus.vector, 16'h0000);
        steps(5);
        rd("rst2_no_edge", 2'd1, 16'h0000);
        bus.irq_src = 8'h00;
        steps(3);
        bus.irq_src = 8'h08;
        steps(3);
        rd("rst2_retoggle", 2'd1, 16'h0008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
